// File: rtl/lutram_pkg.sv
// Shared types and defaults for the LUT-RAM stream reader.
package lutram_pkg;
   localparam int DATA_W = 72;
   localparam int ADDR_W = 10;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/lutram_rd_skid.sv
// Two-entry valid/ready skid FIFO that absorbs in-flight RAM reads under backpressure.
module lutram_rd_skid #(
   parameter int W = 73
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   occ
);
   logic [1:0][W-1:0] mem_q, mem_d;
   logic              wr_q, wr_d, rd_q, rd_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop;

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = mem_q[rd_q];
   assign occ       = cnt_q;
   assign pop       = out_valid & pop_ready;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[wr_q] = push_data;
         wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/lutram_stream_reader.sv
// Read-side sequencer: walks (base, len) through a registered-read LUT RAM and
// streams the words out over valid/ready.
module lutram_stream_reader
   import lutram_pkg::*;
#(
   parameter int DATA = DATA_W,
   parameter int ADDR = ADDR_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [ADDR-1:0] cmd_base,
   input  logic [ADDR:0]   cmd_len,
   output logic [ADDR-1:0] ram_addr,
   input  logic [DATA-1:0] ram_dout,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DATA-1:0] out_data,
   output logic            out_last,
   output logic            busy,
   output logic            done
);
   localparam logic [ADDR-1:0] A_ONE = 1;
   localparam logic [ADDR:0]   L_ONE = 1;

   state_t          state_q, state_d;
   logic [ADDR-1:0] addr_q, addr_d;
   logic [ADDR:0]   len_q, len_d, issued_q, issued_d;
   logic            pend_q, pend_d, pend_last_q, pend_last_d;
   logic [1:0]      occ;
   logic [2:0]      in_use;
   logic            pop, skid_valid;
   logic [DATA:0]   head;

   assign pop    = skid_valid & out_ready;
   assign in_use = {1'b0, occ} + {2'b0, pend_q};

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      issued_d    = issued_q;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d   = cmd_base;
               len_d    = cmd_len;
               issued_d = '0;
               state_d  = (cmd_len == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            // A beat leaving this cycle frees a slot, so back-to-back reads never bubble.
            if (in_use < (3'd2 + {2'b0, pop})) begin
               addr_d      = addr_q + A_ONE;
               issued_d    = issued_q + L_ONE;
               pend_d      = 1'b1;
               pend_last_d = (issued_q + L_ONE == len_q);
               if (issued_q + L_ONE == len_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head[DATA]) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
      end
   end

   lutram_rd_skid #(.W(DATA + 1)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (pend_q),
      .push_data ({pend_last_q, ram_dout}),
      .pop_ready (out_ready),
      .out_valid (skid_valid),
      .out_data  (head),
      .occ       (occ)
   );

   assign ram_addr  = addr_q;
   assign out_valid = skid_valid;
   assign out_data  = head[DATA-1:0];
   assign out_last  = skid_valid & head[DATA];
   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
endmodule

// File: tb/tb_lutram_stream_reader.sv
// Directed + randomized bench for lutram_stream_reader, two instances (ADDR=10 and ADDR=4).
module tb_lutram_stream_reader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid [2], cmd_ready [2], out_valid [2], out_ready [2];
   logic        out_last [2], busy [2], done [2];
   logic [9:0]  cmd_base [2];
   logic [10:0] cmd_len [2];
   logic [71:0] ram_dout [2], out_data [2];
   logic [9:0]  ra10;
   logic [3:0]  ra4;
   int checks = 0;
   int errors = 0;

   lutram_stream_reader #(.DATA(72), .ADDR(10)) u10 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_base(cmd_base[0]), .cmd_len(cmd_len[0]), .ram_addr(ra10), .ram_dout(ram_dout[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .out_last(out_last[0]), .busy(busy[0]), .done(done[0]));

   lutram_stream_reader #(.DATA(72), .ADDR(4)) u4 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_base(cmd_base[1][3:0]), .cmd_len(cmd_len[1][4:0]), .ram_addr(ra4), .ram_dout(ram_dout[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .out_last(out_last[1]), .busy(busy[1]), .done(done[1]));

   // RAM model: mem[i] = 0x100 + i, one-cycle registered read
   always @(posedge clk) begin
      ram_dout[0] <= 72'h100 + 72'(ra10);
      ram_dout[1] <= 72'h100 + 72'(ra4);
   end

   function automatic logic [9:0] raddr(input int d);
      return (d != 0) ? {6'd0, ra4} : ra10;
   endfunction

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int d);
      chk("rst_cmd_ready", cmd_ready[d], 1'b1);
      chk("rst_out_valid", out_valid[d], 1'b0);
      chk("rst_out_last", out_last[d], 1'b0);
      chk("rst_busy", busy[d], 1'b0);
      chk("rst_done", done[d], 1'b0);
      chk("rst_ram_addr", raddr(d), 72'd0);
   endtask

   // One command on instance d; mode 0 = out_ready held 1, mode 1 = 1,0,0,1,0 pattern with random stalls.
   task automatic run(input int d, input int base, input int len, input int mode,
                      input bit poke, input int abort_at);
      int mask = (d != 0) ? 15 : 1023;
      int k = 0;
      int cyc = 0;
      int budget = 100 + len * 12;
      bit stall = 1'b0;
      bit fin = 1'b0;
      bit rdy;
      logic [71:0] pdata = '0;
      logic        plast = 1'b0;
      logic [4:0]  pat = 5'b01001;
      @(negedge clk);
      chk("idle_ready", cmd_ready[d], 1'b1);
      cmd_valid[d] = 1'b1;
      cmd_base[d]  = 10'(base);
      cmd_len[d]   = 11'(len);
      @(negedge clk);
      cmd_valid[d] = 1'b0;
      if (len == 0) begin
         chk("len0_done", done[d], 1'b1);
         chk("len0_valid", out_valid[d], 1'b0);
         @(negedge clk);
         chk("len0_done_drop", done[d], 1'b0);
         chk("len0_ready", cmd_ready[d], 1'b1);
         chk("len0_valid2", out_valid[d], 1'b0);
         return;
      end
      chk("first_addr", raddr(d), 72'(base & mask));
      while (!fin) begin
         if (cyc > budget) begin
            chk("timeout", 1'b0, 1'b1);
            return;
         end
         if (abort_at >= 0 && k == abort_at) begin
            rst_n = 1'b0;
            out_ready[d] = 1'b0;
            #1;
            chk_reset(d);
            @(negedge clk);
            chk("rst_no_done", done[d], 1'b0);
            chk("rst_no_valid", out_valid[d], 1'b0);
            rst_n = 1'b1;
            return;
         end
         if (cyc < 2) chk("lat_pre", out_valid[d], 1'b0);
         else if (cyc == 2) chk("lat_rise", out_valid[d], 1'b1);
         if (stall) begin
            chk("stall_valid", out_valid[d], 1'b1);
            chk("stall_data", out_data[d], pdata);
            chk("stall_last", out_last[d], plast);
         end
         chk("busy", busy[d], 1'b1);
         chk("no_early_done", done[d], 1'b0);
         if (poke) begin
            if (cyc == 3) begin
               cmd_valid[d] = 1'b1;
               cmd_base[d]  = 10'd0;
               cmd_len[d]   = 11'd1;
            end
            if (cyc >= 3 && cyc <= 5) chk("cmd_ready_busy", cmd_ready[d], 1'b0);
            if (cyc == 6) cmd_valid[d] = 1'b0;
         end
         if (mode == 0 && cyc >= 2) chk("no_bubble", out_valid[d], 1'b1);
         rdy = (mode == 0) ? 1'b1 : (pat[cyc % 5] && ($urandom_range(3) != 0));
         out_ready[d] = rdy;
         if (out_valid[d] && rdy) begin
            chk("beat_data", out_data[d], 72'h100 + 72'((base + k) & mask));
            chk("beat_last", out_last[d], 1'(k == len - 1));
            k++;
            if (k == len) fin = 1'b1;
            stall = 1'b0;
         end else begin
            stall = out_valid[d];
            pdata = out_data[d];
            plast = out_last[d];
         end
         cyc++;
         @(negedge clk);
      end
      out_ready[d] = 1'b0;
      chk("done_pulse", done[d], 1'b1);
      chk("done_busy", busy[d], 1'b1);
      chk("done_no_valid", out_valid[d], 1'b0);
      chk("done_not_ready", cmd_ready[d], 1'b0);
      @(negedge clk);
      chk("done_drop", done[d], 1'b0);
      chk("idle_busy", busy[d], 1'b0);
      chk("idle_ready_again", cmd_ready[d], 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         cmd_valid[i] = 1'b0;
         cmd_base[i]  = '0;
         cmd_len[i]   = '0;
         out_ready[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk_reset(0);
      chk_reset(1);
      rst_n = 1'b1;

      run(0, 0, 4, 0, 1'b0, -1);
      run(1, 14, 4, 0, 1'b0, -1);
      run(0, 5, 16, 1, 1'b0, -1);
      run(0, 7, 0, 0, 1'b0, -1);
      run(1, 3, 16, 0, 1'b1, -1);
      run(0, 0, 1, 1, 1'b0, -1);
      run(0, 1020, 9, 1, 1'b0, -1);
      run(0, 0, 8, 0, 1'b0, 3);
      run(0, 0, 2, 0, 1'b0, -1);
      for (int i = 0; i < 6; i++)
         run(i % 2, int'($urandom_range(1023)), int'($urandom_range(1, 24)), 1, 1'b0, -1);
      run(0, 512, 1024, 0, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
